md_unit: RTL
============

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the MIPS pipeline.
- Consumes the forwarded E-stage rs/rt operands (post-forwarding-mux values) and holds the architectural HI/LO registers.
- Drives a busy/stall indication to the hazard unit so that mult/div/mfhi/mflo/mthi/mtlo in D stall while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (must be >= 1).
- DIV_CYCLES, 10, busy duration of div/divu in cycles (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- A  input  32  forwarded rs operand (E stage).
- B  input  32  forwarded rt operand (E stage).
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- start  input  1  E-stage instruction is valid and md_op is to be executed this cycle.
- rd_hi  input  1  1 selects HI onto md_out, 0 selects LO (mfhi/mflo).
- busy  output  1  registered; operation in flight.
- md_stall  output  1  combinational: busy | (start & md_op in 1..4).
- md_out  output  32  combinational: rd_hi ? HI : LO.
- hi  output  32  registered HI.
- lo  output  32  registered LO.

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-high. Reset clears HI=0, LO=0, busy=0, counter=0, state=IDLE.
- Reset mid-operation aborts the operation. No result is written; HI/LO read 0.
- States:
  - IDLE: accepts start.
  - BUSY: counts down.
- IDLE, start=1, md_op in {1,2}:
  - Latch A, B and op. Compute the 64-bit product (signed for mult, unsigned for multu) into a result register.
  - Load counter=MULT_CYCLES. Go to BUSY; busy=1 from the next cycle.
- IDLE, start=1, md_op in {3,4}: same as multiply, with counter=DIV_CYCLES.
  - LO=quotient, HI=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- IDLE, start=1, md_op=5/6: HI (resp. LO) <= A at this edge. Single cycle; busy stays 0.
- BUSY: counter decrements each cycle.
  - On the edge where counter==1: HI/LO <= result, busy <= 0, state <= IDLE.
  - busy is high for exactly N cycles after the start edge.
- Divide by zero (B==0, div/divu): busy timing is unchanged, but HI/LO are not written at completion.
- start while BUSY: ignored, with no state change. The hazard unit guarantees this via md_stall; the bench checks that it is ignored.
- md_out/hi/lo reflect committed values only. Intermediate results are never visible before completion.
- mfhi/mflo during BUSY is stalled externally. md_out during BUSY returns the old HI/LO.
- The result is held in a dedicated register, so A/B changing during BUSY (pipeline advancing) has no effect.
- md_op=0/7 with start=1: no-op.

Optional Feature:
- Macro: MD_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit).
  - cancel=1 while BUSY returns the unit to IDLE at the next edge: busy=0, HI/LO unchanged (pre-operation values), counter=0.
  - cancel=1 in IDLE is a no-op.
  - cancel=1 together with start in IDLE: cancel wins, nothing starts, and mthi/mtlo are suppressed.
  - Used for exception flush.
- Not defined: no cancel port. Operations always run to completion or until reset.

Test Plan:
- Reset mid-div: start div 100/7, assert reset in cycle 3 -> busy=0, HI=0, LO=0 immediately (asynchronous); no later write.
- mult signed: A=0xFFFFFFFE (-2), B=3, start -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; md_stall=1 in the start cycle.
- divu/div: divu A=100, B=7 -> after 10 cycles LO=14, HI=2. div A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: mthi 0x1234, mtlo 0x5678, then div A=5, B=0 -> busy 10 cycles, HI=0x1234 and LO=0x5678 unchanged.
- Start while busy: multu 0xFFFFFFFF x 2, pulse start with div in cycle 2 -> ignored. Completes at cycle 5 with HI=1, LO=0xFFFFFFFE; busy returns to 0 on schedule.
- MD_CANCEL_EN: HI=LO=0xAAAA5555, start mult 3x4, cancel in cycle 2 -> busy=0 next cycle, HI=LO=0xAAAA5555. Without the macro, the same mult gives LO=12, HI=0.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the E stage of a MIPS pipeline.
// Holds the architectural HI/LO registers. The result of mult/multu/div/divu is
// computed when the operation is accepted and kept in a private register; it is
// committed to HI/LO only when the busy countdown expires, so partial results
// are never visible. Optional build macro MD_CANCEL_EN adds a 'cancel' input
// that aborts an in-flight operation, used for exception flush.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  md_op,
    input  logic        start,
    input  logic        rd_hi,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] counter_reg;
    logic [63:0]   result_reg;
    logic          commit_reg;   // cleared for divide by zero: HI/LO keep their values
    logic          busy_reg;
    logic [31:0]   hi_reg;
    logic [31:0]   lo_reg;

    logic          cancel_in;

`ifdef MD_CANCEL_EN
    assign cancel_in = cancel;
`else
    assign cancel_in = 1'b0;
`endif

    // Multiplier: sign- or zero-extend to 64 bits; the low 64 bits of the
    // extended product are the exact signed/unsigned product.
    logic        is_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;

    assign is_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
    assign ext_a     = {{32{is_signed & A[31]}}, A};
    assign ext_b     = {{32{is_signed & B[31]}}, B};
    assign product   = ext_a * ext_b;

    // Divider: divide magnitudes, then fix the signs. Quotient is negative when
    // operand signs differ (truncation toward zero); remainder follows the
    // dividend. 0x80000000 / -1 falls out naturally as 0x80000000, remainder 0.
    // A zero divisor is replaced by 1 so the datapath never produces X; the
    // result is discarded in that case anyway.
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    assign a_neg       = is_signed & A[31];
    assign b_neg       = is_signed & B[31];
    assign abs_a       = a_neg ? (~A + 32'd1) : A;
    assign abs_b       = b_neg ? (~B + 32'd1) : B;
    assign div_by_zero = (B == 32'd0);
    assign divisor     = div_by_zero ? 32'd1 : abs_b;
    assign q_mag       = abs_a / divisor;
    assign r_mag       = abs_a % divisor;
    assign quotient    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign remainder   = a_neg ? (~r_mag + 32'd1) : r_mag;

    // Control FSM, HI/LO registers and the pending-result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            result_reg  <= '0;
            commit_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A cancel in IDLE flushes any instruction presented with it.
                    if (start && !cancel_in) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                result_reg  <= product;
                                commit_reg  <= 1'b1;
                                counter_reg <= CW'(MULT_CYCLES);
                                busy_reg    <= 1'b1;
                                state_reg   <= BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                result_reg  <= {remainder, quotient};
                                commit_reg  <= !div_by_zero;
                                counter_reg <= CW'(DIV_CYCLES);
                                busy_reg    <= 1'b1;
                                state_reg   <= BUSY;
                            end
                            OP_MTHI: hi_reg <= A;
                            OP_MTLO: lo_reg <= A;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    // New starts are ignored here; the hazard unit stalls them.
                    if (cancel_in) begin
                        counter_reg <= '0;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end else if (counter_reg == CW'(1)) begin
                        if (commit_reg) begin
                            hi_reg <= result_reg[63:32];
                            lo_reg <= result_reg[31:0];
                        end
                        counter_reg <= '0;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        counter_reg <= counter_reg - CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign md_out   = rd_hi ? hi_reg : lo_reg;
    assign md_stall = busy_reg | (start & (md_op >= OP_MULT) & (md_op <= OP_DIVU));

endmodule
